// File: rtl/core_interrupts_if.sv
// rtl/core_interrupts_if.sv - CSR access and trap-request bundle for core_interrupts
interface core_interrupts_if #(
   parameter int CAUSE_W = 6
);
   logic               csr_en;
   logic               csr_wr;
   logic [11:0]        csr_addr;
   logic [63:0]        csr_wdata;
   logic [63:0]        csr_rdata;
   logic               csr_error;
   logic               int_req;
   logic [CAUSE_W-1:0] int_cause;
   logic               int_ack;
   logic               int_ret;

   modport master (
      output csr_en, csr_wr, csr_addr, csr_wdata, int_ack, int_ret,
      input  csr_rdata, csr_error, int_req, int_cause
   );

   modport slave (
      input  csr_en, csr_wr, csr_addr, csr_wdata, int_ack, int_ret,
      output csr_rdata, csr_error, int_req, int_cause
   );
endinterface

// File: rtl/core_interrupts.sv
// rtl/core_interrupts.sv - machine interrupt controller owning mip/mie, fixed-priority req/ack to trap logic
// CORE_INT_EXT_SYNC_EN adds a 2-flop synchroniser on ext_interrupt ahead of mip.MEIP.
module core_interrupts #(
   parameter int CAUSE_W = 6
) (
   input  logic             g_clk,
   input  logic             g_resetn,
   input  logic             timer_interrupt,
   input  logic             ext_interrupt,
   input  logic             mstatus_mie,
   core_interrupts_if.slave bus
);
   localparam logic [11:0] MIE_ADDR = 12'h304;
   localparam logic [11:0] MIP_ADDR = 12'h344;
   localparam logic [CAUSE_W-1:0] C_MEI = CAUSE_W'(11);
   localparam logic [CAUSE_W-1:0] C_MSI = CAUSE_W'(3);
   localparam logic [CAUSE_W-1:0] C_MTI = CAUSE_W'(7);

   typedef enum logic [1:0] {S_IDLE, S_REQ, S_TAKEN} state_t;

   state_t             state, state_nxt;
   logic [CAUSE_W-1:0] cause_q, cause_nxt;
   logic               meie, mtie, msie;
   logic               meip, mtip, msip;
   logic               ext_src;
   logic               wr_mie, wr_mip;
   logic               pend_mei, pend_msi, pend_mti;
   logic               latched_pend;
   logic [63:0]        mie_val, mip_val;
   logic               unused_wdata;

`ifdef CORE_INT_EXT_SYNC_EN
   logic ext_s1, ext_s2;

   always_ff @(posedge g_clk) begin
      if (!g_resetn) begin
         ext_s1 <= 1'b0;
         ext_s2 <= 1'b0;
      end else begin
         ext_s1 <= ext_interrupt;
         ext_s2 <= ext_s1;
      end
   end

   assign ext_src = ext_s2;
`else
   assign ext_src = ext_interrupt;
`endif

   // only bits 11/7/3 of the write data are architectural
   assign unused_wdata = ^bus.csr_wdata;

   assign wr_mie = bus.csr_en && bus.csr_wr && (bus.csr_addr == MIE_ADDR);
   assign wr_mip = bus.csr_en && bus.csr_wr && (bus.csr_addr == MIP_ADDR);

   always_ff @(posedge g_clk) begin
      if (!g_resetn) begin
         meie <= 1'b0;
         mtie <= 1'b0;
         msie <= 1'b0;
         meip <= 1'b0;
         mtip <= 1'b0;
         msip <= 1'b0;
      end else begin
         if (wr_mie) begin
            meie <= bus.csr_wdata[11];
            mtie <= bus.csr_wdata[7];
            msie <= bus.csr_wdata[3];
         end
         if (wr_mip) begin
            msip <= bus.csr_wdata[3];
         end
         meip <= ext_src;
         mtip <= timer_interrupt;
      end
   end

   always_comb begin
      mie_val     = '0;
      mie_val[11] = meie;
      mie_val[7]  = mtie;
      mie_val[3]  = msie;
      mip_val     = '0;
      mip_val[11] = meip;
      mip_val[7]  = mtip;
      mip_val[3]  = msip;
   end

   always_comb begin
      bus.csr_rdata = '0;
      bus.csr_error = 1'b0;
      if (bus.csr_en) begin
         if (bus.csr_addr == MIE_ADDR) begin
            bus.csr_rdata = mie_val;
         end else if (bus.csr_addr == MIP_ADDR) begin
            bus.csr_rdata = mip_val;
         end else begin
            bus.csr_error = 1'b1;
         end
      end
   end

   assign pend_mei = meip && meie;
   assign pend_msi = msip && msie;
   assign pend_mti = mtip && mtie;

   always_comb begin
      latched_pend = 1'b0;
      case (cause_q)
         C_MEI:   latched_pend = pend_mei;
         C_MSI:   latched_pend = pend_msi;
         C_MTI:   latched_pend = pend_mti;
         default: latched_pend = 1'b0;
      endcase
   end

   always_ff @(posedge g_clk) begin
      if (!g_resetn) begin
         state   <= S_IDLE;
         cause_q <= '0;
      end else begin
         state   <= state_nxt;
         cause_q <= cause_nxt;
      end
   end

   // once requested, the cause is frozen; ack beats withdrawal
   always_comb begin
      state_nxt = state;
      cause_nxt = cause_q;
      case (state)
         S_IDLE: begin
            if (mstatus_mie && (pend_mei || pend_msi || pend_mti)) begin
               state_nxt = S_REQ;
               cause_nxt = pend_mei ? C_MEI : (pend_msi ? C_MSI : C_MTI);
            end
         end
         S_REQ: begin
            if (bus.int_ack) begin
               state_nxt = S_TAKEN;
            end else if (!latched_pend || !mstatus_mie) begin
               state_nxt = S_IDLE;
            end
         end
         S_TAKEN: begin
            if (bus.int_ret) begin
               state_nxt = S_IDLE;
            end
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   assign bus.int_req   = (state == S_REQ);
   assign bus.int_cause = cause_q;
endmodule

// File: tb/tb_core_interrupts.sv
// tb/tb_core_interrupts.sv - vector table, corner sequences and randomized model check for core_interrupts
module tb_core_interrupts;
   logic g_clk = 1'b0;
   logic g_resetn, timer_interrupt, ext_interrupt, mstatus_mie;
   int   n_cmp = 0;
   int   n_fail = 0;

   core_interrupts_if #(.CAUSE_W(6)) bus ();

   core_interrupts #(.CAUSE_W(6)) dut (
      .g_clk           (g_clk),
      .g_resetn        (g_resetn),
      .timer_interrupt (timer_interrupt),
      .ext_interrupt   (ext_interrupt),
      .mstatus_mie     (mstatus_mie),
      .bus             (bus)
   );

   always #5 g_clk = ~g_clk;

`ifdef CORE_INT_EXT_SYNC_EN
   localparam int EXT_LAT = 4;
`else
   localparam int EXT_LAT = 2;
`endif
   localparam logic [63:0] ALL1 = 64'hFFFF_FFFF_FFFF_FFFF;

   // architectural model: registers as plain values, request/taken as flags
   logic [63:0] m_mie, m_mip;
   logic        m_req, m_taken, m_ext_d1, m_ext_d2;
   logic [5:0]  m_cause;

   initial begin
      m_mie = '0; m_mip = '0; m_req = 0; m_taken = 0;
      m_ext_d1 = 0; m_ext_d2 = 0; m_cause = '0;
   end

   function automatic logic [5:0] top_cause(input logic [63:0] pend);
      int pri[3];
      pri[0] = 11; pri[1] = 3; pri[2] = 7;
      for (int k = 0; k < 3; k++) begin
         if (pend[pri[k]]) return 6'(pri[k]);
      end
      return 6'd0;
   endfunction

   task automatic model_update();
      logic [63:0] pend;
      logic        meip_new, msip_new;
      pend = m_mip & m_mie;
      if (!g_resetn) begin
         m_mie = '0; m_mip = '0; m_req = 0; m_taken = 0;
         m_ext_d1 = 0; m_ext_d2 = 0; m_cause = '0;
         return;
      end
      if (m_taken) begin
         if (bus.int_ret) m_taken = 0;
      end else if (m_req) begin
         if (bus.int_ack) begin m_req = 0; m_taken = 1; end
         else if (!pend[m_cause] || !mstatus_mie) m_req = 0;
      end else if (mstatus_mie && pend != 0) begin
         m_req = 1;
         m_cause = top_cause(pend);
      end
      msip_new = m_mip[3];
      if (bus.csr_en && bus.csr_wr && bus.csr_addr == 12'h344) msip_new = bus.csr_wdata[3];
      if (bus.csr_en && bus.csr_wr && bus.csr_addr == 12'h304) m_mie = bus.csr_wdata & 64'h888;
`ifdef CORE_INT_EXT_SYNC_EN
      meip_new = m_ext_d2;
      m_ext_d2 = m_ext_d1;
      m_ext_d1 = ext_interrupt;
`else
      meip_new = ext_interrupt;
`endif
      m_mip = '0;
      m_mip[11] = meip_new;
      m_mip[7]  = timer_interrupt;
      m_mip[3]  = msip_new;
   endtask

   function automatic logic [63:0] model_rdata();
      if (!bus.csr_en) return '0;
      if (bus.csr_addr == 12'h304) return m_mie;
      if (bus.csr_addr == 12'h344) return m_mip;
      return '0;
   endfunction

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic cyc();
      @(posedge g_clk);
      model_update();
      @(negedge g_clk);
   endtask

   task automatic drive(input logic rn, input logic tim, input logic ext, input logic mst,
                        input logic en, input logic wr, input logic [11:0] addr,
                        input logic [63:0] wd, input logic ack, input logic ret);
      g_resetn = rn; timer_interrupt = tim; ext_interrupt = ext; mstatus_mie = mst;
      bus.csr_en = en; bus.csr_wr = wr; bus.csr_addr = addr; bus.csr_wdata = wd;
      bus.int_ack = ack; bus.int_ret = ret;
   endtask

   typedef struct {
      logic        rn, tim, mst, en, wr;
      logic [11:0] addr;
      logic [63:0] wd;
      logic        ack, ret;
      logic        e_req;
      logic [5:0]  e_cause;
      logic [63:0] e_rd;
      logic        e_err;
   } vec_t;

   function automatic vec_t V(input logic rn, input logic tim, input logic mst, input logic en,
                              input logic wr, input logic [11:0] addr, input logic [63:0] wd,
                              input logic ack, input logic ret, input logic e_req,
                              input logic [5:0] e_cause, input logic [63:0] e_rd, input logic e_err);
      vec_t v;
      v.rn = rn; v.tim = tim; v.mst = mst; v.en = en; v.wr = wr; v.addr = addr; v.wd = wd;
      v.ack = ack; v.ret = ret; v.e_req = e_req; v.e_cause = e_cause; v.e_rd = e_rd; v.e_err = e_err;
      return v;
   endfunction

   task automatic wait_req(input string nm);
      int n = 0;
      while (!bus.int_req && n < 12) begin cyc(); n++; end
      chk(nm, 64'(bus.int_req), 64'd1);
   endtask

   vec_t tbl[$];

   initial begin
      // rn tim mst en wr addr wdata ack ret | req cause rdata err
      tbl.push_back(V(0,0,0,0,0,12'h000,64'h0,0,0, 0,0,64'h0,0));   // 0
      tbl.push_back(V(0,0,0,0,0,12'h000,64'h0,0,0, 0,0,64'h0,0));
      tbl.push_back(V(1,0,1,1,1,12'h304,64'h80,0,0, 0,0,64'h0,0));
      tbl.push_back(V(1,0,1,1,0,12'h304,64'h0,0,0, 0,0,64'h80,0));
      tbl.push_back(V(1,0,1,0,0,12'h000,64'h0,0,0, 0,0,64'h0,0));
      tbl.push_back(V(1,1,1,0,0,12'h000,64'h0,0,0, 0,0,64'h0,0));   // 5 timer rises
      tbl.push_back(V(1,1,1,1,0,12'h344,64'h0,0,0, 0,0,64'h80,0));
      tbl.push_back(V(1,1,1,0,0,12'h000,64'h0,0,0, 1,7,64'h0,0));   // 7 request
      tbl.push_back(V(1,1,1,0,0,12'h000,64'h0,1,0, 1,7,64'h0,0));
      tbl.push_back(V(1,1,1,0,0,12'h000,64'h0,0,0, 0,7,64'h0,0));
      tbl.push_back(V(1,0,1,0,0,12'h000,64'h0,0,1, 0,7,64'h0,0));   // 10 ret
      tbl.push_back(V(1,0,1,0,0,12'h000,64'h0,0,0, 0,7,64'h0,0));
      tbl.push_back(V(1,0,1,1,1,12'h304,ALL1,0,0, 0,7,64'h80,0));
      tbl.push_back(V(1,0,1,1,0,12'h304,64'h0,0,0, 0,7,64'h888,0));
      tbl.push_back(V(1,0,1,1,0,12'h305,64'h0,0,0, 0,7,64'h0,1));
      tbl.push_back(V(1,0,1,1,1,12'h305,ALL1,0,0, 0,7,64'h0,1));    // 15
      tbl.push_back(V(1,0,1,1,1,12'h344,ALL1,0,0, 0,7,64'h0,0));
      tbl.push_back(V(1,1,1,1,0,12'h344,64'h0,0,0, 0,7,64'h8,0));
      tbl.push_back(V(1,1,1,0,0,12'h000,64'h0,0,0, 1,3,64'h0,0));
      tbl.push_back(V(1,1,1,1,0,12'h344,64'h0,0,0, 1,3,64'h88,0));
      tbl.push_back(V(1,1,1,1,1,12'h344,64'h0,0,0, 1,3,64'h88,0));   // 20 clear MSIP
      tbl.push_back(V(1,1,1,0,0,12'h000,64'h0,0,0, 1,3,64'h0,0));
      tbl.push_back(V(1,0,1,0,0,12'h000,64'h0,0,0, 0,3,64'h0,0));
      tbl.push_back(V(1,0,1,0,0,12'h000,64'h0,1,0, 1,7,64'h0,0));   // ack + drop
      tbl.push_back(V(1,0,1,0,0,12'h000,64'h0,0,0, 0,7,64'h0,0));
      tbl.push_back(V(1,1,1,0,0,12'h000,64'h0,0,0, 0,7,64'h0,0));   // 25
      tbl.push_back(V(1,1,1,0,0,12'h000,64'h0,0,1, 0,7,64'h0,0));
      tbl.push_back(V(1,1,1,0,0,12'h000,64'h0,0,0, 0,7,64'h0,0));
      tbl.push_back(V(1,1,0,0,0,12'h000,64'h0,0,0, 1,7,64'h0,0));
      tbl.push_back(V(1,1,0,0,0,12'h000,64'h0,0,0, 0,7,64'h0,0));
      tbl.push_back(V(1,1,1,0,0,12'h000,64'h0,0,0, 0,7,64'h0,0));   // 30
      tbl.push_back(V(0,1,1,0,0,12'h000,64'h0,0,0, 1,7,64'h0,0));   // reset in REQ
      tbl.push_back(V(1,1,1,1,0,12'h304,64'h0,0,0, 0,0,64'h0,0));

      foreach (tbl[i]) begin
         drive(tbl[i].rn, tbl[i].tim, 1'b0, tbl[i].mst, tbl[i].en, tbl[i].wr,
               tbl[i].addr, tbl[i].wd, tbl[i].ack, tbl[i].ret);
         #1;
         chk($sformatf("tbl%0d_req", i),   64'(bus.int_req),   64'(tbl[i].e_req));
         chk($sformatf("tbl%0d_cause", i), 64'(bus.int_cause), 64'(tbl[i].e_cause));
         chk($sformatf("tbl%0d_rdata", i), bus.csr_rdata,      tbl[i].e_rd);
         chk($sformatf("tbl%0d_err", i),   64'(bus.csr_error), 64'(tbl[i].e_err));
         cyc();
      end

      // all three sources pending: MEI first, then MSI after MEI drops
      drive(0,0,0,0,0,0,12'h000,64'h0,0,0); cyc();
      drive(1,0,1,0,1,1,12'h304,64'h888,0,0); cyc();
      drive(1,1,1,0,1,1,12'h344,64'h8,0,0); cyc();
      drive(1,1,1,0,0,0,12'h000,64'h0,0,0);
      repeat (5) cyc();
      mstatus_mie = 1;
      wait_req("prio_req");
      chk("prio_mei", 64'(bus.int_cause), 64'd11);
      bus.int_ack = 1; ext_interrupt = 0; cyc();
      bus.int_ack = 0;
      repeat (5) cyc();
      chk("prio_taken_req", 64'(bus.int_req), 64'd0);
      bus.int_ret = 1; cyc();
      bus.int_ret = 0;
      wait_req("prio_req2");
      chk("prio_msi", 64'(bus.int_cause), 64'd3);

      // mie cleared while in REQ, no ack: withdraw by C+2
      drive(1,1,1,0,1,1,12'h304,64'h0,0,0); cyc();
      drive(1,1,1,0,0,0,12'h000,64'h0,0,0); cyc();
      chk("wd_req", 64'(bus.int_req), 64'd0);
      bus.csr_en = 1; bus.csr_addr = 12'h304; #1;
      chk("wd_mie", bus.csr_rdata, 64'h0);

      // external source latency
      drive(0,0,0,1,0,0,12'h000,64'h0,0,0); cyc();
      drive(1,0,0,1,1,1,12'h304,64'h800,0,0); cyc();
      drive(1,0,0,1,0,0,12'h000,64'h0,0,0);
      repeat (4) cyc();
      ext_interrupt = 1;
      begin
         int n = 0;
         while (!bus.int_req && n < 12) begin cyc(); n++; end
         chk("ext_latency", 64'(n), 64'(EXT_LAT));
      end

      // randomized run against the model
      drive(0,0,0,0,0,0,12'h000,64'h0,0,0); cyc();
      for (int c = 0; c < 1500; c++) begin
         logic [11:0] a;
         case ($urandom_range(3))
            0: a = 12'h304;
            1: a = 12'h344;
            2: a = 12'h305;
            default: a = 12'($urandom);
         endcase
         g_resetn        = ($urandom_range(99) != 0);
         if ($urandom_range(7) == 0) timer_interrupt = ~timer_interrupt;
         if ($urandom_range(9) == 0) ext_interrupt = ~ext_interrupt;
         mstatus_mie     = ($urandom_range(7) != 0);
         bus.csr_en      = ($urandom_range(2) == 0);
         bus.csr_wr      = 1'($urandom);
         bus.csr_addr    = a;
         bus.csr_wdata   = {$urandom, $urandom};
         bus.int_ack     = ($urandom_range(2) == 0);
         bus.int_ret     = ($urandom_range(3) == 0);
         #1;
         chk("rnd_req",   64'(bus.int_req),   64'(m_req));
         chk("rnd_cause", 64'(bus.int_cause), 64'(m_cause));
         chk("rnd_rdata", bus.csr_rdata,      model_rdata());
         chk("rnd_err",   64'(bus.csr_error),
             64'(bus.csr_en && bus.csr_addr != 12'h304 && bus.csr_addr != 12'h344));
         cyc();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end
endmodule

// File: doc/core_interrupts.md
# core_interrupts

Machine-level interrupt controller sitting directly downstream of `core_counters`. It consumes the level `timer_interrupt` together with external and software interrupt sources, and owns the `mip` and `mie` CSRs. It arbitrates pending, enabled interrupts by fixed priority and presents a single interrupt request, with cause, to the pipeline trap logic over a req/ack handshake.

## Interface
Parameters:
- `CAUSE_W`, 6, width of `int_cause`.

Ports:
- `g_clk`  in  1  global clock.
- `g_resetn`  in  1  reset; synchronous, active-low.
- `timer_interrupt`  in  1  level MTI source from `core_counters` (already registered there).
- `ext_interrupt`  in  1  level MEI source from the platform.
- `mstatus_mie`  in  1  global machine interrupt enable.
- `csr_en`  in  1  CSR access valid.
- `csr_wr`  in  1  CSR write (else read).
- `csr_addr`  in  12  CSR address.
- `csr_wdata`  in  64  CSR write data.
- `csr_rdata`  out  64  CSR read data, combinational.
- `csr_error`  out  1  unmapped CSR address, combinational.
- `int_req`  out  1  interrupt request to trap logic.
- `int_cause`  out  CAUSE_W  cause code of `int_req`.
- `int_ack`  in  1  trap logic has taken the request.
- `int_ret`  in  1  `mret` retired.

## Operation
- `mie` at 0x304: writable bits MEIE[11], MTIE[7], MSIE[3]; all other bits read 0, writes ignored.
- `mip` at 0x344:
  - MEIP[11] and MTIP[7] are read-only. Each cycle they are registered from `ext_interrupt` and `timer_interrupt`.
  - MSIP[3] is writable. All other bits read 0.
- CSR access:
  - A read returns the register value. `csr_rdata` is 0 when `csr_en` is low or the address is unmapped.
  - `csr_error` = `csr_en` && address is neither 0x304 nor 0x344.
  - Writes take effect at the next edge.
  - Writes to read-only `mip` bits are silently dropped.
- `pending` = `mip & mie`. Priority is MEI (cause 11) > MSI (cause 3) > MTI (cause 7).
- FSM, 3 states:
  - IDLE:
    - If `mstatus_mie && |pending`, latch the highest-priority cause and go to REQ.
  - REQ:
    - `int_req` = 1 and `int_cause` = latched cause.
    - If `int_ack`, go to TAKEN.
    - Else, if the latched source's `pending` bit is 0 or `mstatus_mie` is 0, go to IDLE (request withdrawn).
    - `int_ack` wins over withdrawal in the same cycle.
  - TAKEN:
    - `int_req` = 0, `int_cause` holds.
    - On `int_ret`, go to IDLE.
- The cause is not pre-empted while in REQ: a higher-priority arrival waits for the next IDLE evaluation.
- `int_ack` outside REQ and `int_ret` outside TAKEN are ignored.
- `mip` and `mie` keep updating in every state.

## Timing
- Reset values:
  - FSM = IDLE, `mie` = 0, `mip` = 0, `int_req` = 0, `int_cause` = 0.
  - `csr_rdata` = 0 and `csr_error` = 0, given `csr_en` is low during reset.
- Source latency: source high in cycle C → `mip` bit set in C+1 → `int_req` high in C+2 (when enabled).
- MSIP via CSR: write in cycle C → `mip`.MSIP set in C+1 → `int_req` high in C+2.
- Handshake:
  - `int_ack` sampled high in cycle C with `int_req` high → `int_req` low in C+1.
  - `int_ret` in cycle C while in TAKEN → IDLE in C+1. The earliest new `int_req` is C+2.
- A `mie` write in the same cycle as the IDLE evaluation:
  - The evaluation uses the pre-write `mie`.
  - If the write disables the latched source, REQ withdraws one cycle later.
- `int_req` and `int_cause` are registered outputs. No combinational path from `int_ack` to `int_req`.
- Synchronous reset mid-operation, from any state: every register returns to its reset value at the next edge. No request survives reset.

## Configuration
- `CORE_INT_EXT_SYNC_EN` defined:
  - `ext_interrupt` passes through a 2-flop synchroniser before `mip`.MEIP.
  - External latency becomes C+4 to `int_req`.
  - The synchroniser flops reset to 0.
- Undefined:
  - `ext_interrupt` is registered directly into `mip`.MEIP.
  - Latency is C+2, same as the other sources.
- The macro does not change timer or software path latency.

## Test plan
- Reset, then `mie`=0x80, `mstatus_mie`=1, `timer_interrupt` high in cycle 5 → `int_req`=1 with `int_cause`=7 in cycle 7; read 0x344 returns 0x80.
- MEI, MSI and MTI all pending with `mie`=0x888 → `int_cause`=11. Ack, then `int_ret`, with MEI dropped → next `int_cause`=3.
- Request in REQ, then a `mie`=0 write in cycle C with no ack → `int_req` low by C+2, FSM back in IDLE.
- `int_ack` and source drop in the same cycle → TAKEN. Stays TAKEN, `int_req`=0, until `int_ret`.
- Write 0xFFFF_FFFF_FFFF_FFFF to 0x304 → read returns 0x888. Access to 0x305 → `csr_error`=1, `csr_rdata`=0.
- With `CORE_INT_EXT_SYNC_EN`: `ext_interrupt` high in cycle 10, `mie`=0x800 → `int_req` in cycle 14. Without the macro → cycle 12.
